level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
//  Game-flow controller for the symmetry-counter datapath. Sequences each level through
//  show-target, timed play and judgement phases, and pulses levelComplete into the judge.
//  Consumes the judge's incLevel/lose verdict to advance the level or end the game.
//  Owns the level number and per-level play timer used by display and pattern logic.
// PARAMETERS
//  LEVEL_W     4      width of level counter
//  MAX_LEVEL   8      last level; passing it -> WON
//  TIMER_W     16     width of tick timer
//  SHOW_TICKS  2000   ticks target pattern is shown before play
//  PLAY_BASE   10000  play ticks at level 1
//  PLAY_DEC    1000   play ticks removed per level above 1
//  PLAY_MIN    2000   floor on play ticks
// PORTS
//  Clk100M        in   1        system clock, 100 MHz
//  Rst_n          in   1        asynchronous active-low reset
//  tick           in   1        1-cycle timebase enable (1 kHz)
//  start          in   1        1-cycle pulse, begin or restart a game
//  userDone       in   1        1-cycle pulse, player submits answer
//  incLevel       in   1        judge verdict: level passed
//  lose           in   1        judge verdict: level failed
//  levelComplete  out  1        1-cycle pulse to judge
//  level          out  LEVEL_W  current level, 1..MAX_LEVEL
//  newLevel       out  1        1-cycle pulse, load pattern for `level`
//  showTarget     out  1        high in SHOW
//  playEnable     out  1        high in PLAY; gates player input counting
//  timeLeft       out  TIMER_W  remaining ticks of current phase
//  gameOver       out  1        high in LOST
//  gameWon        out  1        high in WON
// BEHAVIOUR
//  Reset (async, Rst_n=0): state IDLE, level=1, timeLeft=0, all 1-bit outputs 0.
//  States: IDLE, SHOW, PLAY, JUDGE, VERDICT, LOST, WON. Registered outputs, Moore.
//  IDLE:    start -> SHOW; level=1; newLevel=1 for that cycle; timeLeft=SHOW_TICKS.
//  SHOW:    timeLeft decrements on tick; on tick with timeLeft==1 -> PLAY, timeLeft=playTicks.
//  PLAY:    decrement on tick. userDone, or tick with timeLeft==1 -> JUDGE.
//           Both in same cycle -> one transition, one levelComplete.
//  JUDGE:   levelComplete=1 for exactly one cycle, -> VERDICT (timeLeft holds).
//  VERDICT: samples incLevel/lose one cycle after the pulse (judge latency = 1).
//           incLevel=1: level==MAX_LEVEL -> WON; else level+1, newLevel pulse, -> SHOW.
//           else lose=1 -> LOST. Neither set (fault) -> LOST. Both set: incLevel wins.
//  LOST/WON: hold outputs; start -> restart as from IDLE (level=1, newLevel pulse).
//  start is ignored in SHOW, PLAY, JUDGE, VERDICT. tick ignored outside SHOW/PLAY.
//  playTicks = max(PLAY_BASE - (level-1)*PLAY_DEC, PLAY_MIN), computed in TIMER_W bits.
//   Saturating: if (level-1)*PLAY_DEC >= PLAY_BASE - PLAY_MIN, result = PLAY_MIN.
//  timeLeft never wraps below 0; a tick at 0 leaves it at 0.
//  showTarget/playEnable/gameOver/gameWon decode from state; exactly one (or none in
//   IDLE/JUDGE/VERDICT) high at a time.
// STRUCTURE
//  Shared package: state encoding constants (3-bit), default timing constants.
//  Sub-module: phase_timer (load value, tick-enabled down-counter, saturating at 0,
//   `expire` = tick & count==1). FSM, level counter and playTicks calc stay in top.
// TESTING
//  1 Reset mid-PLAY: Rst_n low -> state IDLE, level=1, outputs 0, same cycle.
//  2 start; 2000 ticks -> playEnable=1, timeLeft=10000; userDone -> levelComplete 1 cycle;
//    incLevel=1 next cycle -> level=2, newLevel pulse, SHOW.
//  3 No userDone at level 3: timeLeft 8000 -> 0 -> levelComplete; lose=1 -> gameOver=1.
//  4 userDone and expiring tick same cycle -> exactly one levelComplete pulse.
//  5 Pass levels 1..8 -> gameWon=1 after level 8; level 9 playTicks check: level 9
//    unreachable; level 8 playTicks=3000; PLAY_DEC=5000 override -> level 3 uses 2000.
//  6 In VERDICT neither verdict asserted -> LOST; start in LOST -> level=1, SHOW.

Source files
------------

// File: rtl/level_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : level_sequencer_pkg
// Description : Shared constants for the level sequencer.
//               - 3-bit state encoding of the game-flow FSM.
//               - Default timing constants used as parameter defaults.
// Revision    : 1.0  initial release
// ============================================================================
package level_sequencer_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SHOW    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_PLAY    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_JUDGE   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_VERDICT = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_LOST    = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_WON     = 3'd6;

    localparam int c_DEF_LEVEL_W    = 4;
    localparam int c_DEF_MAX_LEVEL  = 8;
    localparam int c_DEF_TIMER_W    = 16;
    localparam int c_DEF_SHOW_TICKS = 2000;
    localparam int c_DEF_PLAY_BASE  = 10000;
    localparam int c_DEF_PLAY_DEC   = 1000;
    localparam int c_DEF_PLAY_MIN   = 2000;

endpackage : level_sequencer_pkg
`default_nettype wire

// File: rtl/level_sequencer_phase_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : level_sequencer_phase_timer
// Description : Loadable tick-enabled down-counter, saturating at zero.
//               Ports:
//                 Clk100M      in   system clock
//                 Rst_n        in   asynchronous active-low reset
//                 i_load       in   load i_load_value (has priority over tick)
//                 i_load_value in   WIDTH  value to load
//                 i_tick       in   decrement enable
//                 o_count      out  WIDTH  current count
//                 o_expire     out  tick arriving while count == 1
// Revision    : 1.0  initial release
// ============================================================================
module level_sequencer_phase_timer
    import level_sequencer_pkg::*;
#(
    parameter int WIDTH = c_DEF_TIMER_W
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_count,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count  = r_count;
    assign o_expire = i_tick && (r_count == WIDTH'(1));

endmodule : level_sequencer_phase_timer
`default_nettype wire

// File: rtl/level_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : level_sequencer
// Description : Game-flow controller. Sequences each level through
//               SHOW -> PLAY -> JUDGE -> VERDICT and ends in LOST or WON.
//               Ports:
//                 Clk100M, Rst_n            clock, async active-low reset
//                 tick                      1 kHz timebase enable
//                 start, userDone           1-cycle control pulses
//                 incLevel, lose            judge verdict, sampled in VERDICT
//                 levelComplete, newLevel   1-cycle pulses
//                 level, timeLeft           level number, phase ticks left
//                 showTarget, playEnable,
//                 gameOver, gameWon         state decodes
// Revision    : 1.0  initial release
// ============================================================================
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int LEVEL_W    = c_DEF_LEVEL_W,
    parameter int MAX_LEVEL  = c_DEF_MAX_LEVEL,
    parameter int TIMER_W    = c_DEF_TIMER_W,
    parameter int SHOW_TICKS = c_DEF_SHOW_TICKS,
    parameter int PLAY_BASE  = c_DEF_PLAY_BASE,
    parameter int PLAY_DEC   = c_DEF_PLAY_DEC,
    parameter int PLAY_MIN   = c_DEF_PLAY_MIN
) (
    input  logic               Clk100M,
    input  logic               Rst_n,
    input  logic               tick,
    input  logic               start,
    input  logic               userDone,
    input  logic               incLevel,
    input  logic               lose,
    output logic               levelComplete,
    output logic [LEVEL_W-1:0] level,
    output logic               newLevel,
    output logic               showTarget,
    output logic               playEnable,
    output logic [TIMER_W-1:0] timeLeft,
    output logic               gameOver,
    output logic               gameWon
);

    // The decrement product is formed wider than the timer so that large
    // PLAY_DEC overrides saturate correctly instead of wrapping.
    localparam int c_PROD_W = TIMER_W + LEVEL_W;
    localparam logic [c_PROD_W-1:0] c_SPAN      = c_PROD_W'(PLAY_BASE - PLAY_MIN);
    localparam logic [TIMER_W-1:0]  c_SHOW      = TIMER_W'(SHOW_TICKS);
    localparam logic [TIMER_W-1:0]  c_BASE      = TIMER_W'(PLAY_BASE);
    localparam logic [TIMER_W-1:0]  c_MIN       = TIMER_W'(PLAY_MIN);
    localparam logic [LEVEL_W-1:0]  c_LEVEL_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0]  c_LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [LEVEL_W-1:0]   r_level;
    logic [LEVEL_W-1:0]   w_level_next;
    logic                 r_new_level;
    logic                 w_new_level_next;
    logic                 r_level_complete;
    logic                 r_show;
    logic                 r_play;
    logic                 r_over;
    logic                 r_won;
    logic                 w_level_complete_next;
    logic                 w_show_next;
    logic                 w_play_next;
    logic                 w_over_next;
    logic                 w_won_next;

    logic                 w_timer_load;
    logic [TIMER_W-1:0]   w_timer_load_value;
    logic                 w_timer_tick;
    logic                 w_expire;
    logic [TIMER_W-1:0]   w_count;

    logic [LEVEL_W-1:0]   w_level_m1;
    logic [c_PROD_W-1:0]  w_dec;
    logic [TIMER_W-1:0]   w_play_ticks;

    // playTicks = max(PLAY_BASE - (level-1)*PLAY_DEC, PLAY_MIN)
    assign w_level_m1   = r_level - c_LEVEL_ONE;
    assign w_dec        = c_PROD_W'(w_level_m1) * c_PROD_W'(PLAY_DEC);
    assign w_play_ticks = (w_dec >= c_SPAN) ? c_MIN : (c_BASE - w_dec[TIMER_W-1:0]);

    // Ticks only count down while a timed phase is active.
    assign w_timer_tick = tick && ((r_state == c_ST_SHOW) || (r_state == c_ST_PLAY));

    level_sequencer_phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .Clk100M      (Clk100M),
        .Rst_n        (Rst_n),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_load_value),
        .i_tick       (w_timer_tick),
        .o_count      (w_count),
        .o_expire     (w_expire)
    );

    // State and registered outputs.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state          <= c_ST_IDLE;
            r_level          <= c_LEVEL_ONE;
            r_new_level      <= 1'b0;
            r_level_complete <= 1'b0;
            r_show           <= 1'b0;
            r_play           <= 1'b0;
            r_over           <= 1'b0;
            r_won            <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_level          <= w_level_next;
            r_new_level      <= w_new_level_next;
            r_level_complete <= w_level_complete_next;
            r_show           <= w_show_next;
            r_play           <= w_play_next;
            r_over           <= w_over_next;
            r_won            <= w_won_next;
        end
    end

    // Next state, level update and timer loads.
    always_comb begin
        w_state_next       = r_state;
        w_level_next       = r_level;
        w_new_level_next   = 1'b0;
        w_timer_load       = 1'b0;
        w_timer_load_value = c_SHOW;
        case (r_state)
            c_ST_IDLE, c_ST_LOST, c_ST_WON: begin
                if (start) begin
                    w_state_next     = c_ST_SHOW;
                    w_level_next     = c_LEVEL_ONE;
                    w_new_level_next = 1'b1;
                    w_timer_load     = 1'b1;
                end
            end
            c_ST_SHOW: begin
                if (w_expire) begin
                    w_state_next       = c_ST_PLAY;
                    w_timer_load       = 1'b1;
                    w_timer_load_value = w_play_ticks;
                end
            end
            c_ST_PLAY: begin
                // A simultaneous submit and timeout is a single transition.
                if (userDone || w_expire) begin
                    w_state_next = c_ST_JUDGE;
                end
            end
            c_ST_JUDGE: begin
                w_state_next = c_ST_VERDICT;
            end
            c_ST_VERDICT: begin
                // incLevel has priority; a missing verdict counts as a loss.
                if (incLevel) begin
                    if (r_level == c_LEVEL_MAX) begin
                        w_state_next = c_ST_WON;
                    end else begin
                        w_state_next     = c_ST_SHOW;
                        w_level_next     = r_level + c_LEVEL_ONE;
                        w_new_level_next = 1'b1;
                        w_timer_load     = 1'b1;
                    end
                end else begin
                    w_state_next = c_ST_LOST;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        w_level_complete_next = (w_state_next == c_ST_JUDGE);
        w_show_next           = (w_state_next == c_ST_SHOW);
        w_play_next           = (w_state_next == c_ST_PLAY);
        w_over_next           = (w_state_next == c_ST_LOST);
        w_won_next            = (w_state_next == c_ST_WON);
    end

    assign levelComplete = r_level_complete;
    assign level         = r_level;
    assign newLevel      = r_new_level;
    assign showTarget    = r_show;
    assign playEnable    = r_play;
    assign timeLeft      = w_count;
    assign gameOver      = r_over;
    assign gameWon       = r_won;

endmodule : level_sequencer
`default_nettype wire

// File: tb/tb_level_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_level_sequencer
// Description : Self-checking bench for level_sequencer. Three instances share
//               the stimulus: A (defaults), B (short timing, 3 levels),
//               C (defaults with PLAY_DEC = 5000).
// Revision    : 1.0  initial release
// ============================================================================
module tb_level_sequencer;

    localparam int S_SHOW = 3;
    localparam int S_BASE = 12;
    localparam int S_DEC  = 5;
    localparam int S_MIN  = 4;
    localparam int S_MAX  = 3;

    logic Clk100M = 1'b0;
    logic Rst_n, tick, start, userDone, incLevel, lose;

    always #5 Clk100M = ~Clk100M;

    logic       a_lc, a_nl, a_show, a_play, a_over, a_won;
    logic [3:0] a_level;
    logic [15:0] a_tl;
    logic       b_lc, b_nl, b_show, b_play, b_over, b_won;
    logic [3:0] b_level;
    logic [15:0] b_tl;
    logic       c_lc, c_nl, c_show, c_play, c_over, c_won;
    logic [3:0] c_level;
    logic [15:0] c_tl;

    logic [31:0] a_pk, b_pk, c_pk;
    assign a_pk = {6'b0, a_level, a_nl, a_show, a_play, a_lc, a_over, a_won, a_tl};
    assign b_pk = {6'b0, b_level, b_nl, b_show, b_play, b_lc, b_over, b_won, b_tl};
    assign c_pk = {6'b0, c_level, c_nl, c_show, c_play, c_lc, c_over, c_won, c_tl};

    level_sequencer u_dut_a (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .tick(tick), .start(start),
        .userDone(userDone), .incLevel(incLevel), .lose(lose),
        .levelComplete(a_lc), .level(a_level), .newLevel(a_nl),
        .showTarget(a_show), .playEnable(a_play), .timeLeft(a_tl),
        .gameOver(a_over), .gameWon(a_won)
    );

    level_sequencer #(
        .SHOW_TICKS(S_SHOW), .PLAY_BASE(S_BASE), .PLAY_DEC(S_DEC),
        .PLAY_MIN(S_MIN), .MAX_LEVEL(S_MAX)
    ) u_dut_b (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .tick(tick), .start(start),
        .userDone(userDone), .incLevel(incLevel), .lose(lose),
        .levelComplete(b_lc), .level(b_level), .newLevel(b_nl),
        .showTarget(b_show), .playEnable(b_play), .timeLeft(b_tl),
        .gameOver(b_over), .gameWon(b_won)
    );

    level_sequencer #(
        .PLAY_DEC(5000)
    ) u_dut_c (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .tick(tick), .start(start),
        .userDone(userDone), .incLevel(incLevel), .lose(lose),
        .levelComplete(c_lc), .level(c_level), .newLevel(c_nl),
        .showTarget(c_show), .playEnable(c_play), .timeLeft(c_tl),
        .gameOver(c_over), .gameWon(c_won)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit tk, st, ud, inc, ls;
        int lvl;
        bit nl, show, play, lc, over, won;
        int tl;
    } vec_t;
    vec_t vecs[$];

    typedef enum {M_IDLE, M_SHOW, M_PLAY, M_JUDGE, M_VERDICT, M_LOST, M_WON} mphase_t;

    function automatic logic [31:0] pk(int lvl, bit nl, bit show, bit play, bit lc,
                                       bit over, bit won, int tl);
        return {6'b0, lvl[3:0], nl, show, play, lc, over, won, tl[15:0]};
    endfunction

    function automatic int play_ticks(int lvl, int base, int dec, int mn);
        int v;
        v = base - (lvl - 1) * dec;
        return (v < mn) ? mn : v;
    endfunction

    function automatic void add(bit tk, bit st, bit ud, bit inc, bit ls, int lvl, bit nl,
                                bit show, bit play, bit lc, bit over, bit won, int tl);
        vec_t v;
        v.tk = tk; v.st = st; v.ud = ud; v.inc = inc; v.ls = ls;
        v.lvl = lvl; v.nl = nl; v.show = show; v.play = play; v.lc = lc;
        v.over = over; v.won = won; v.tl = tl;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit s, input bit u, input bit i, input bit l);
        tick = t; start = s; userDone = u; incLevel = i; lose = l;
        @(posedge Clk100M);
        #1;
        tick = 0; start = 0; userDone = 0; incLevel = 0; lose = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        Rst_n = 0;
        tick = 0; start = 0; userDone = 0; incLevel = 0; lose = 0;
        repeat (2) @(posedge Clk100M);
        #1;
        Rst_n = 1;
    endtask

    initial begin
        mphase_t m_ph;
        int m_lvl, m_tl, pulses;
        bit m_nl, fin, t, s, u, i, l;

        // Vector table for instance B: full short game, verdict corners, LOST/WON restarts.
        //   tk st ud in ls  lvl nl sh pl lc ov wn  tl
        add(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0,  3);
        add(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0,  2);
        add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0,  2);
        add(1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0,  1);
        add(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 12);
        add(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 11);
        add(0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0, 11);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 11);
        add(0, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0, 0,  3);
        add(1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0,  2);
        add(1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0,  1);
        add(1, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0,  7);
        add(1, 0, 1, 0, 0,  2, 0, 0, 0, 1, 0, 0,  6);
        add(0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0,  6);
        add(0, 0, 0, 1, 1,  3, 1, 1, 0, 0, 0, 0,  3);
        add(1, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 0,  2);
        add(1, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 0,  1);
        add(1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0,  4);
        add(1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0,  3);
        add(1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0,  2);
        add(1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0, 0,  1);
        add(1, 0, 0, 0, 0,  3, 0, 0, 0, 1, 0, 0,  0);
        add(1, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0, 1, 0,  3, 0, 0, 0, 0, 0, 1,  0);
        add(1, 0, 0, 1, 0,  3, 0, 0, 0, 0, 0, 1,  0);
        add(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0,  3);
        add(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0,  2);
        add(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0,  1);
        add(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 12);
        add(0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0, 12);
        add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 12);
        add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 12);
        add(1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 12);
        add(0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0,  3);

        // Reset state of every instance.
        do_reset();
        chk("reset_a", a_pk, pk(1, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_b", b_pk, pk(1, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_c", c_pk, pk(1, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            cyc(vecs[k].tk, vecs[k].st, vecs[k].ud, vecs[k].inc, vecs[k].ls);
            chk($sformatf("vec%0d", k), b_pk,
                pk(vecs[k].lvl, vecs[k].nl, vecs[k].show, vecs[k].play, vecs[k].lc,
                   vecs[k].over, vecs[k].won, vecs[k].tl));
        end

        // userDone together with the expiring tick: one levelComplete pulse.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        ticks(S_SHOW + S_BASE - 1);
        chk("t4_before", b_pk, pk(1, 0, 0, 1, 0, 0, 0, 1));
        cyc(1, 0, 1, 0, 0);
        chk("t4_judge", b_pk, pk(1, 0, 0, 0, 1, 0, 0, 0));
        pulses = int'(b_lc);
        repeat (4) begin
            cyc(1, 0, 1, 0, 0);
            pulses += int'(b_lc);
        end
        chk("t4_single_pulse", 32'(pulses), 32'(1));

        // Asynchronous reset in the middle of PLAY, no clock edge needed.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        ticks(2000);
        chk("t1_in_play", a_pk, pk(1, 0, 0, 1, 0, 0, 0, 10000));
        #2;
        Rst_n = 0;
        #1;
        chk("t1_async_reset", a_pk, pk(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge Clk100M);
        #1;
        Rst_n = 1;

        // Level 1 pass, then level 3 timeout and loss, on the default instance.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        chk("t2_start", a_pk, pk(1, 1, 1, 0, 0, 0, 0, 2000));
        ticks(1999);
        chk("t2_show_end", a_pk, pk(1, 0, 1, 0, 0, 0, 0, 1));
        ticks(1);
        chk("t2_play", a_pk, pk(1, 0, 0, 1, 0, 0, 0, 10000));
        cyc(0, 0, 1, 0, 0);
        chk("t2_lc", a_pk, pk(1, 0, 0, 0, 1, 0, 0, 10000));
        cyc(0, 0, 0, 0, 0);
        chk("t2_verdict", a_pk, pk(1, 0, 0, 0, 0, 0, 0, 10000));
        cyc(0, 0, 0, 1, 0);
        chk("t2_level2", a_pk, pk(2, 1, 1, 0, 0, 0, 0, 2000));
        ticks(2000);
        chk("t3_l2_play", a_pk, pk(2, 0, 0, 1, 0, 0, 0, 9000));
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        ticks(2000);
        chk("t3_l3_play", a_pk, pk(3, 0, 0, 1, 0, 0, 0, 8000));
        ticks(7999);
        chk("t3_last_tick", a_pk, pk(3, 0, 0, 1, 0, 0, 0, 1));
        ticks(1);
        chk("t3_timeout", a_pk, pk(3, 0, 0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t3_lost", a_pk, pk(3, 0, 0, 0, 0, 1, 0, 0));

        // Pass all levels; C checks the saturated play time with a large decrement.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        for (int lv = 1; lv <= 8; lv++) begin
            ticks(2000);
            chk($sformatf("t5_play_l%0d", lv), a_pk,
                pk(lv, 0, 0, 1, 0, 0, 0, play_ticks(lv, 10000, 1000, 2000)));
            if (lv == 8) chk("t5_l8_ticks", 32'(a_tl), 32'(3000));
            if (lv == 2) chk("t5_c_l2_ticks", 32'(c_tl), 32'(5000));
            if (lv == 3) chk("t5_c_l3_ticks", 32'(c_tl), 32'(2000));
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, 0);
            if (lv < 8)
                chk($sformatf("t5_next_l%0d", lv), a_pk, pk(lv + 1, 1, 1, 0, 0, 0, 0, 2000));
            else
                chk("t5_won", a_pk, pk(8, 0, 0, 0, 0, 0, 1, 3000));
        end

        // Randomized run of instance B against a behavioural model.
        do_reset();
        m_ph = M_IDLE; m_lvl = 1; m_tl = 0; m_nl = 0;
        for (int n = 0; n < 3000; n++) begin
            t = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 15) == 0);
            u = ($urandom_range(0, 7) == 0);
            i = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
            m_nl = 0;
            case (m_ph)
                M_IDLE, M_LOST, M_WON: begin
                    if (s) begin
                        m_ph = M_SHOW; m_lvl = 1; m_nl = 1; m_tl = S_SHOW;
                    end
                end
                M_SHOW: begin
                    if (t) begin
                        if (m_tl == 1) begin
                            m_ph = M_PLAY;
                            m_tl = play_ticks(m_lvl, S_BASE, S_DEC, S_MIN);
                        end else if (m_tl > 0) begin
                            m_tl--;
                        end
                    end
                end
                M_PLAY: begin
                    fin = u || (t && m_tl == 1);
                    if (t && m_tl > 0) m_tl--;
                    if (fin) m_ph = M_JUDGE;
                end
                M_JUDGE: m_ph = M_VERDICT;
                default: begin
                    if (i) begin
                        if (m_lvl == S_MAX) begin
                            m_ph = M_WON;
                        end else begin
                            m_lvl++; m_nl = 1; m_ph = M_SHOW; m_tl = S_SHOW;
                        end
                    end else begin
                        m_ph = M_LOST;
                    end
                end
            endcase
            cyc(t, s, u, i, l);
            chk($sformatf("rand%0d", n), b_pk,
                pk(m_lvl, m_nl, m_ph == M_SHOW, m_ph == M_PLAY, m_ph == M_JUDGE,
                   m_ph == M_LOST, m_ph == M_WON, m_tl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_level_sequencer
`default_nettype wire
